// File: rtl/cpu_pkg.sv
// Shared types for the Rv32H decode stage: operation classes, RV32I opcodes
// and the decode FSM state encoding.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_LUI,
    OP_AUIPC,
    OP_JAL,
    OP_JALR,
    OP_BRANCH,
    OP_LOAD,
    OP_STORE,
    OP_ALUI,
    OP_ALU,
    OP_SYSTEM,
    OP_ILLEGAL
  } op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DISPATCH
  } state_e;

endpackage

// File: rtl/cpu_decode_fields.sv
// Combinational RV32I field decoder: operation class, register indices with
// use flags (unused indices forced to 0) and the sign-extended immediate.
module cpu_decode_fields
  import cpu_pkg::*;
(
  input  logic [31:0] instr_i,
  output op_e         op_o,
  output logic [4:0]  rs1_idx_o,
  output logic [4:0]  rs2_idx_o,
  output logic [4:0]  rd_idx_o,
  output logic        use_rs1_o,
  output logic        use_rs2_o,
  output logic [31:0] imm_o
);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        writes_rd;

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    op_o      = OP_ILLEGAL;
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    writes_rd = 1'b0;
    imm_o     = '0;
    case (instr_i[6:0])
      OPC_LUI:    begin op_o = OP_LUI;    writes_rd = 1'b1; imm_o = imm_u; end
      OPC_AUIPC:  begin op_o = OP_AUIPC;  writes_rd = 1'b1; imm_o = imm_u; end
      OPC_JAL:    begin op_o = OP_JAL;    writes_rd = 1'b1; imm_o = imm_j; end
      OPC_JALR:   begin op_o = OP_JALR;   writes_rd = 1'b1; use_rs1_o = 1'b1; imm_o = imm_i; end
      OPC_LOAD:   begin op_o = OP_LOAD;   writes_rd = 1'b1; use_rs1_o = 1'b1; imm_o = imm_i; end
      OPC_OP_IMM: begin op_o = OP_ALUI;   writes_rd = 1'b1; use_rs1_o = 1'b1; imm_o = imm_i; end
      OPC_BRANCH: begin op_o = OP_BRANCH; use_rs1_o = 1'b1; use_rs2_o = 1'b1; imm_o = imm_b; end
      OPC_STORE:  begin op_o = OP_STORE;  use_rs1_o = 1'b1; use_rs2_o = 1'b1; imm_o = imm_s; end
      OPC_OP:     begin op_o = OP_ALU;    writes_rd = 1'b1; use_rs1_o = 1'b1; use_rs2_o = 1'b1; end
      OPC_SYSTEM: begin op_o = OP_SYSTEM; imm_o = imm_i; end
      default:    ;
    endcase
  end

  assign rs1_idx_o = use_rs1_o ? instr_i[19:15] : 5'd0;
  assign rs2_idx_o = use_rs2_o ? instr_i[24:20] : 5'd0;
  assign rd_idx_o  = writes_rd ? instr_i[11:7]  : 5'd0;

endmodule

// File: rtl/cpu_decode.sv
// Decode/operand-fetch stage: accepts one instruction per fetch-tag change,
// resolves RAW/WAW hazards via a register scoreboard, reads operands, dispatches.
module cpu_decode
  import cpu_pkg::*;
#(
  parameter logic [31:0] SP_RESET = 32'h0001_0400
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [7:0]  i_fetch_tag,
  input  logic [31:0] i_instruction,
  input  logic [31:0] i_pc,
  output logic        o_busy,
  output logic [7:0]  o_read_tag,
  output logic [4:0]  o_read_rs1_idx,
  output logic [4:0]  o_read_rs2_idx,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [7:0]  i_write_tag,
  input  logic [4:0]  i_write_rd_idx,
  input  logic        i_execute_busy,
  output logic [7:0]  o_tag,
  output logic [31:0] o_pc,
  output logic [31:0] o_rs1,
  output logic [31:0] o_rs2,
  output logic [31:0] o_imm,
  output logic [4:0]  o_rd_idx,
  output logic [3:0]  o_op,
  output logic [2:0]  o_funct3,
  output logic        o_funct7b5
);

  logic unused_sp_reset;
  assign unused_sp_reset = ^SP_RESET;

  state_e      state_q, state_d;
  logic [7:0]  ftag_q, wtag_q, read_tag_q, tag_q;
  logic [31:0] sb_q, sb_d;
  logic [31:0] instr_q, pc_q;
  logic [4:0]  rs1_idx_q, rs2_idx_q, rd_q;
  logic [31:0] pc_out_q, rs1_q, rs2_q, imm_q;
  op_e         op_q;
  logic [2:0]  funct3_q;
  logic        f7b5_q;
  logic        accept, issue, dispatch, hazard;

  op_e         dec_op;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_use1, dec_use2;
  logic [31:0] dec_imm;

  cpu_decode_fields u_fields (
    .instr_i   (instr_q),
    .op_o      (dec_op),
    .rs1_idx_o (dec_rs1),
    .rs2_idx_o (dec_rs2),
    .rd_idx_o  (dec_rd),
    .use_rs1_o (dec_use1),
    .use_rs2_o (dec_use2),
    .imm_o     (dec_imm)
  );

  // RAW on either used source, or WAW on a still-pending destination.
  assign hazard = (dec_use1 && sb_q[dec_rs1]) || (dec_use2 && sb_q[dec_rs2]) ||
                  ((dec_rd != 5'd0) && sb_q[dec_rd]);

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    issue    = 1'b0;
    dispatch = 1'b0;
    case (state_q)
      ST_IDLE:     if (i_fetch_tag != ftag_q) begin accept = 1'b1; state_d = ST_ISSUE; end
      ST_ISSUE:    if (!hazard) begin issue = 1'b1; state_d = ST_WAIT; end
      ST_WAIT:     state_d = ST_DISPATCH;
      ST_DISPATCH: if (!i_execute_busy) begin dispatch = 1'b1; state_d = ST_IDLE; end
      default:     state_d = ST_IDLE;
    endcase
  end

  // A set from this cycle's issue overrides a write-back clear to the same index.
  always_comb begin
    sb_d = sb_q;
    if (i_write_tag != wtag_q) sb_d[i_write_rd_idx] = 1'b0;
    if (issue && (dec_rd != 5'd0)) sb_d[dec_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge i_clock) begin
    if (accept) begin
      instr_q <= i_instruction;
      pc_q    <= i_pc;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      ftag_q     <= '0;
      wtag_q     <= '0;
      sb_q       <= '0;
      read_tag_q <= '0;
      rs1_idx_q  <= '0;
      rs2_idx_q  <= '0;
      tag_q      <= '0;
      pc_out_q   <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      op_q       <= OP_LUI;
      funct3_q   <= '0;
      f7b5_q     <= 1'b0;
    end else begin
      wtag_q <= i_write_tag;
      sb_q   <= sb_d;
      if (accept) ftag_q <= i_fetch_tag;
      if (issue) begin
        read_tag_q <= read_tag_q + 8'd1;
        rs1_idx_q  <= dec_rs1;
        rs2_idx_q  <= dec_rs2;
      end
      if (dispatch) begin
        tag_q    <= tag_q + 8'd1;
        pc_out_q <= pc_q;
        rs1_q    <= i_rs1;
        rs2_q    <= i_rs2;
        imm_q    <= dec_imm;
        rd_q     <= dec_rd;
        op_q     <= dec_op;
        funct3_q <= instr_q[14:12];
        f7b5_q   <= instr_q[30];
      end
    end
  end

  assign o_busy         = (state_q != ST_IDLE);
  assign o_read_tag     = read_tag_q;
  assign o_read_rs1_idx = rs1_idx_q;
  assign o_read_rs2_idx = rs2_idx_q;
  assign o_tag          = tag_q;
  assign o_pc           = pc_out_q;
  assign o_rs1          = rs1_q;
  assign o_rs2          = rs2_q;
  assign o_imm          = imm_q;
  assign o_rd_idx       = rd_q;
  assign o_op           = op_q;
  assign o_funct3       = funct3_q;
  assign o_funct7b5     = f7b5_q;

endmodule

// File: tb/tb_cpu_decode.sv
// Directed bench for cpu_decode: hand-computed vectors covering dispatch
// latency, RAW stall, immediates, execute backpressure, illegal ops, reset.
module tb_cpu_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  fetch_tag;
  logic [31:0] instruction, pc;
  logic        busy;
  logic [7:0]  read_tag;
  logic [4:0]  rs1_idx, rs2_idx;
  logic [31:0] rs1_in, rs2_in;
  logic [7:0]  write_tag;
  logic [4:0]  write_rd_idx;
  logic        exec_busy;
  logic [7:0]  tag;
  logic [31:0] pc_o, rs1_o, rs2_o, imm_o;
  logic [4:0]  rd_o;
  logic [3:0]  op_o;
  logic [2:0]  funct3_o;
  logic        f7b5_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [3:0] E_LUI = 4'd0, E_BRANCH = 4'd4, E_ALUI = 4'd7,
                         E_ALU = 4'd8, E_ILLEGAL = 4'd10;

  always #5 clk = ~clk;

  cpu_decode dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_fetch_tag    (fetch_tag),
    .i_instruction  (instruction),
    .i_pc           (pc),
    .o_busy         (busy),
    .o_read_tag     (read_tag),
    .o_read_rs1_idx (rs1_idx),
    .o_read_rs2_idx (rs2_idx),
    .i_rs1          (rs1_in),
    .i_rs2          (rs2_in),
    .i_write_tag    (write_tag),
    .i_write_rd_idx (write_rd_idx),
    .i_execute_busy (exec_busy),
    .o_tag          (tag),
    .o_pc           (pc_o),
    .o_rs1          (rs1_o),
    .o_rs2          (rs2_o),
    .o_imm          (imm_o),
    .o_rd_idx       (rd_o),
    .o_op           (op_o),
    .o_funct3       (funct3_o),
    .o_funct7b5     (f7b5_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_rtag"}, {24'd0, read_tag}, 32'd0);
    chk({name, "_ridx"}, {22'd0, rs1_idx, rs2_idx}, 32'd0);
    chk({name, "_tag"}, {24'd0, tag}, 32'd0);
    chk({name, "_pc"}, pc_o, 32'd0);
    chk({name, "_rs"}, rs1_o | rs2_o, 32'd0);
    chk({name, "_imm"}, imm_o, 32'd0);
    chk({name, "_fields"}, {19'd0, rd_o, op_o, funct3_o, f7b5_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; fetch_tag = 8'd0; instruction = 32'd0; pc = 32'd0;
    rs1_in = 32'd0; rs2_in = 32'd0; write_tag = 8'd0; write_rd_idx = 5'd0;
    exec_busy = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // addi x1,x0,5
    instruction = 32'h00500093; pc = 32'h100; fetch_tag = 8'd1;
    tick();
    chk("addi_busy", {31'd0, busy}, 32'd1);
    chk("addi_rtag_e0", {24'd0, read_tag}, 32'd0);
    tick();
    chk("addi_rtag_e1", {24'd0, read_tag}, 32'd1);
    chk("addi_ridx", {22'd0, rs1_idx, rs2_idx}, 32'd0);
    tick(); tick();
    chk("addi_tag", {24'd0, tag}, 32'd1);
    chk("addi_op", {28'd0, op_o}, {28'd0, E_ALUI});
    chk("addi_imm", imm_o, 32'd5);
    chk("addi_rd", {27'd0, rd_o}, 32'd1);
    chk("addi_pc", pc_o, 32'h100);
    chk("addi_idle", {31'd0, busy}, 32'd0);

    // add x2,x1,x1 stalls on x1 until the write-back of x1
    instruction = 32'h00108133; pc = 32'h104; fetch_tag = 8'd2;
    tick(); tick(); tick(); tick();
    chk("raw_stall_rtag", {24'd0, read_tag}, 32'd1);
    chk("raw_stall_busy", {31'd0, busy}, 32'd1);
    write_tag = 8'd1; write_rd_idx = 5'd1;
    tick();
    chk("raw_clear_edge_rtag", {24'd0, read_tag}, 32'd1);
    tick();
    chk("raw_issue_rtag", {24'd0, read_tag}, 32'd2);
    chk("raw_issue_ridx", {22'd0, rs1_idx, rs2_idx}, {22'd0, 5'd1, 5'd1});
    rs1_in = 32'h12345678; rs2_in = 32'h12345678;
    tick(); tick();
    chk("add_tag", {24'd0, tag}, 32'd2);
    chk("add_rs1", rs1_o, 32'h12345678);
    chk("add_rs2", rs2_o, 32'h12345678);
    chk("add_rd_op", {23'd0, rd_o, op_o}, {23'd0, 5'd2, E_ALU});
    write_tag = 8'd2; write_rd_idx = 5'd2;
    rs1_in = 32'd0; rs2_in = 32'd0;
    tick();

    // beq x0,x0,-4
    instruction = 32'hFE000EE3; pc = 32'h108; fetch_tag = 8'd3;
    tick(); tick();
    chk("beq_rtag", {24'd0, read_tag}, 32'd3);
    tick(); tick();
    chk("beq_tag", {24'd0, tag}, 32'd3);
    chk("beq_imm", imm_o, 32'hFFFFFFFC);
    chk("beq_rd_op", {23'd0, rd_o, op_o}, {23'd0, 5'd0, E_BRANCH});

    // lui x3,0x12345 with execute backpressure for 10 cycles
    exec_busy = 1'b1;
    instruction = 32'h123451B7; pc = 32'h10C; fetch_tag = 8'd4;
    tick(); tick(); tick();
    for (int i = 0; i < 10; i++) tick();
    chk("stall_tag", {24'd0, tag}, 32'd3);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    exec_busy = 1'b0;
    tick();
    chk("lui_tag", {24'd0, tag}, 32'd4);
    chk("lui_imm", imm_o, 32'h12345000);
    chk("lui_rd_op", {23'd0, rd_o, op_o}, {23'd0, 5'd3, E_LUI});
    write_tag = 8'd3; write_rd_idx = 5'd3;
    tick();

    // illegal opcode with nonzero rd/rs1 fields
    instruction = 32'h000F8FFF; pc = 32'h110; fetch_tag = 8'd5;
    tick(); tick();
    chk("ill_rtag", {24'd0, read_tag}, 32'd5);
    chk("ill_ridx", {22'd0, rs1_idx, rs2_idx}, 32'd0);
    tick(); tick();
    chk("ill_tag", {24'd0, tag}, 32'd5);
    chk("ill_rd_op", {23'd0, rd_o, op_o}, {23'd0, 5'd0, E_ILLEGAL});

    // tag 255 then 0, the second change arriving while busy
    instruction = 32'h00000013; pc = 32'h114; fetch_tag = 8'd255;
    tick();
    instruction = 32'hFFF00213; pc = 32'h118; fetch_tag = 8'd0;
    tick();
    chk("t255_rtag", {24'd0, read_tag}, 32'd6);
    tick(); tick();
    chk("t255_tag", {24'd0, tag}, 32'd6);
    chk("t255_pc", pc_o, 32'h114);
    chk("t255_imm", imm_o, 32'd0);
    tick(); tick();
    chk("t0_rtag", {24'd0, read_tag}, 32'd7);
    tick(); tick();
    chk("t0_tag", {24'd0, tag}, 32'd7);
    chk("t0_pc", pc_o, 32'h118);
    chk("t0_imm", imm_o, 32'hFFFFFFFF);
    chk("t0_rd", {27'd0, rd_o}, 32'd4);

    // addi x6,x0,1 abandoned by reset in WAIT; x4 remains pending until reset
    instruction = 32'h00100313; pc = 32'h11C; fetch_tag = 8'd1;
    tick(); tick();
    chk("wait_rtag", {24'd0, read_tag}, 32'd8);
    rst = 1'b1; fetch_tag = 8'd0; write_tag = 8'd0; write_rd_idx = 5'd0;
    #2;
    chk_all_zero("midreset");
    tick();
    rst = 1'b0;
    tick();

    // add x7,x4,x4 must issue without a stall after reset
    instruction = 32'h004203B3; pc = 32'h120; fetch_tag = 8'd1;
    tick(); tick();
    chk("post_rtag", {24'd0, read_tag}, 32'd1);
    chk("post_ridx", {22'd0, rs1_idx, rs2_idx}, {22'd0, 5'd4, 5'd4});
    rs1_in = 32'hCAFE0004; rs2_in = 32'hCAFE0004;
    tick(); tick();
    chk("post_tag", {24'd0, tag}, 32'd1);
    chk("post_rs1", rs1_o, 32'hCAFE0004);
    chk("post_rd_op", {23'd0, rd_o, op_o}, {23'd0, 5'd7, E_ALU});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
